// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared tile geometry, inst bit map and sequencer states for core
//
// Purpose : constants shared by the core instruction sequencer and its helpers.
//           Holds the tile geometry, the 47-bit inst field positions, the
//           all-idle inst word and the sequencer state encoding.
// Ports   : none (package).

package core_pkg;

   // Tile geometry
   localparam int ROW      = 8;
   localparam int COL      = 8;
   localparam int IN_W     = 6;
   localparam int K_W      = 3;
   localparam int OUT_W    = IN_W - K_W + 1;
   localparam int LEN_NIJ  = IN_W * IN_W;
   localparam int LEN_KIJ  = K_W * K_W;
   localparam int LEN_ONIJ = OUT_W * OUT_W;
   localparam int GAP_CYC  = 10;

   // Instruction word layout
   localparam int INST_W      = 47;
   localparam int AW          = 11;
   localparam int B_CEN_X     = 46;
   localparam int B_WEN_X     = 45;
   localparam int B_AX_LO     = 34;
   localparam int B_ACC       = 33;
   localparam int B_CEN_P     = 32;
   localparam int B_WEN_P     = 31;
   localparam int B_AP_LO     = 20;
   localparam int B_CEN_W     = 19;
   localparam int B_WEN_W     = 18;
   localparam int B_AW_LO     = 7;
   localparam int B_OFIFO_RD  = 6;
   localparam int B_IFIFO_WR  = 5;
   localparam int B_IFIFO_RD  = 4;
   localparam int B_L0_RD     = 3;
   localparam int B_L0_WR     = 2;
   localparam int B_EXECUTE   = 1;
   localparam int B_LOAD      = 0;

   // All SRAM chip/write enables deasserted (active-low), every strobe off
   localparam logic [INST_W-1:0] INST_IDLE = 47'h6001_800C_0000;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_W_RD,
      ST_W_LOAD,
      ST_GAP,
      ST_X_RD,
      ST_EXEC,
      ST_O_RD,
      ST_ACC,
      ST_ACC_DRAIN
   } seq_state_t;

endpackage

// File: rtl/psum_addr_gen.sv
// rtl/psum_addr_gen.sv - psum SRAM read address for accumulation of output pixel o, kernel slot j
//
// Purpose : maps (o, j) to the psum SRAM address holding the partial sum of
//           kernel position j that contributes to output pixel o:
//              A_p = j*len_nij + (oy+ky)*in_w + (ox+kx)
//           Result is registered; output is zero when sel is low so it can be
//           OR-merged into an instruction word.
// Ports   : clk   in  clock
//           reset in  asynchronous active-low reset
//           sel   in  register a real address this cycle (else zero)
//           o     in  output pixel index 0..len_onij-1
//           j     in  kernel position 0..len_kij-1
//           a_p   out registered psum address

module psum_addr_gen
   import core_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          sel,
   input  logic [4:0]    o,
   input  logic [3:0]    j,
   output logic [AW-1:0] a_p
);

   logic [4:0]    oy;
   logic [4:0]    ox;
   logic [3:0]    ky;
   logic [3:0]    kx;
   logic [AW-1:0] a_d;

   always_comb begin
      oy  = o / 5'(OUT_W);
      ox  = o % 5'(OUT_W);
      ky  = j / 4'(K_W);
      kx  = j % 4'(K_W);
      a_d = AW'(j) * AW'(LEN_NIJ)
          + (AW'(oy) + AW'(ky)) * AW'(IN_W)
          + AW'(ox) + AW'(kx);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_p <= '0;
      end else begin
         a_p <= sel ? a_d : '0;
      end
   end

endmodule

// File: rtl/core_inst_sequencer.sv
// rtl/core_inst_sequencer.sv - generates the core inst word for one full conv tile
//
// Purpose : walks every kernel position (weight read/load, gap, activation
//           read, execute, OFIFO drain into psum SRAM), then accumulates the
//           psums of every output pixel. All outputs are registered and follow
//           the internal state by one clock.
// Ports   : clk          in  clock, rising edge
//           reset        in  asynchronous active-low reset
//           start        in  start one tile (accepted only in IDLE)
//           ofifo_valid  in  core OFIFO has a readable row
//           inst         out 47-bit instruction word
//           busy         out high whenever not idle
//           done         out one-cycle pulse when the tile completes
//           kij_idx      out current kernel position
//           onij_idx     out current output pixel during accumulation, else 0

module core_inst_sequencer
   import core_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              ofifo_valid,
   output logic [INST_W-1:0] inst,
   output logic              busy,
   output logic              done,
   output logic [3:0]        kij_idx,
   output logic [4:0]        onij_idx
);

   localparam int CNT_W = 7;

   // Last value of the phase counter in each fixed-length phase
   localparam logic [CNT_W-1:0] T_W_RD_END  = CNT_W'(COL);
   localparam logic [CNT_W-1:0] T_LOAD_END  = CNT_W'(ROW + COL - 2);
   localparam logic [CNT_W-1:0] T_GAP_END   = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] T_X_RD_END  = CNT_W'(LEN_NIJ);
   localparam logic [CNT_W-1:0] T_EXEC_END  = CNT_W'(LEN_NIJ + ROW + COL - 2);
   localparam logic [CNT_W-1:0] T_O_RD_LAST = CNT_W'(LEN_NIJ - 1);
   localparam logic [CNT_W-1:0] T_ACC_END   = CNT_W'(LEN_KIJ);
   localparam logic [3:0]       KIJ_LAST    = 4'(LEN_KIJ - 1);
   localparam logic [4:0]       ONIJ_LAST   = 5'(LEN_ONIJ - 1);

   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  t_q, t_d;
   logic [3:0]        kij_q, kij_d;
   logic [4:0]        onij_q, onij_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              done_d;
   logic              acc_sel;
   logic [AW-1:0]     ap_acc;

   always_comb begin
      state_d = state_q;
      t_d     = t_q + 1'b1;
      kij_d   = kij_q;
      onij_d  = onij_q;
      inst_d  = INST_IDLE;
      acc_sel = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            t_d = '0;
            // done is still high in the first IDLE cycle; a start there is dropped
            if (start && !done) begin
               state_d = ST_W_RD;
               kij_d   = '0;
               onij_d  = '0;
            end
         end

         ST_W_RD: begin
            if (t_q < T_W_RD_END) begin
               inst_d[B_CEN_W]          = 1'b0;
               inst_d[B_AW_LO +: AW]    = AW'(kij_q) * AW'(COL) + AW'(t_q);
            end
            // L0 write lags each SRAM read by the 1-cycle read latency
            if (t_q != '0) inst_d[B_L0_WR] = 1'b1;
            if (t_q == T_W_RD_END) begin
               state_d = ST_W_LOAD;
               t_d     = '0;
            end
         end

         ST_W_LOAD: begin
            inst_d[B_L0_RD] = 1'b1;
            inst_d[B_LOAD]  = 1'b1;
            if (t_q == T_LOAD_END) begin
               state_d = ST_GAP;
               t_d     = '0;
            end
         end

         ST_GAP: begin
            if (t_q == T_GAP_END) begin
               state_d = ST_X_RD;
               t_d     = '0;
            end
         end

         ST_X_RD: begin
            if (t_q < T_X_RD_END) begin
               inst_d[B_CEN_X]       = 1'b0;
               inst_d[B_AX_LO +: AW] = AW'(t_q);
            end
            if (t_q != '0) inst_d[B_L0_WR] = 1'b1;
            if (t_q == T_X_RD_END) begin
               state_d = ST_EXEC;
               t_d     = '0;
            end
         end

         ST_EXEC: begin
            inst_d[B_L0_RD]   = 1'b1;
            inst_d[B_EXECUTE] = 1'b1;
            if (t_q == T_EXEC_END) begin
               state_d = ST_O_RD;
               t_d     = '0;
            end
         end

         ST_O_RD: begin
            // t counts completed reads here, so it holds while the OFIFO is empty
            t_d = t_q;
            if (ofifo_valid) begin
               inst_d[B_OFIFO_RD]    = 1'b1;
               inst_d[B_CEN_P]       = 1'b0;
               inst_d[B_WEN_P]       = 1'b0;
               inst_d[B_AP_LO +: AW] = AW'(kij_q) * AW'(LEN_NIJ) + AW'(t_q);
               if (t_q == T_O_RD_LAST) begin
                  t_d = '0;
                  if (kij_q == KIJ_LAST) begin
                     state_d = ST_ACC;
                     onij_d  = '0;
                  end else begin
                     kij_d   = kij_q + 1'b1;
                     state_d = ST_W_RD;
                  end
               end else begin
                  t_d = t_q + 1'b1;
               end
            end
         end

         ST_ACC: begin
            // Read address comes from psum_addr_gen, merged into inst below
            if (t_q < T_ACC_END) begin
               inst_d[B_CEN_P] = 1'b0;
               acc_sel         = 1'b1;
            end
            if (t_q != '0) inst_d[B_ACC] = 1'b1;
            if (t_q == T_ACC_END) begin
               state_d = ST_ACC_DRAIN;
               t_d     = '0;
            end
         end

         ST_ACC_DRAIN: begin
            t_d = '0;
            if (onij_q == ONIJ_LAST) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               onij_d  = onij_q + 1'b1;
               state_d = ST_ACC;
            end
         end

         default: begin
            state_d = ST_IDLE;
            t_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         t_q      <= '0;
         kij_q    <= '0;
         onij_q   <= '0;
         inst_q   <= INST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         kij_idx  <= '0;
         onij_idx <= '0;
      end else begin
         state_q  <= state_d;
         t_q      <= t_d;
         kij_q    <= kij_d;
         onij_q   <= onij_d;
         inst_q   <= inst_d;
         busy     <= (state_q != ST_IDLE);
         done     <= done_d;
         kij_idx  <= kij_q;
         onij_idx <= (state_q == ST_ACC || state_q == ST_ACC_DRAIN) ? onij_q : '0;
      end
   end

   // Registered alongside inst_q from the same (onij, t), so the two stay aligned
   psum_addr_gen u_psum_addr_gen (
      .clk   (clk),
      .reset (reset),
      .sel   (acc_sel),
      .o     (onij_q),
      .j     (t_q[3:0]),
      .a_p   (ap_acc)
   );

   // inst_q carries a zero A_p field in ACC, so OR-merging is exact
   assign inst = {inst_q[INST_W-1:B_AP_LO+AW],
                  inst_q[B_AP_LO +: AW] | ap_acc,
                  inst_q[B_AP_LO-1:0]};

endmodule

// File: tb/tb_core_inst_sequencer.sv
// tb/tb_core_inst_sequencer.sv - self-checking bench for core_inst_sequencer

module tb_core_inst_sequencer;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        ofifo_valid;
   logic [46:0] inst;
   logic        busy;
   logic        done;
   logic [3:0]  kij_idx;
   logic [4:0]  onij_idx;

   always #5 clk = ~clk;

   core_inst_sequencer dut (
      .clk         (clk),
      .reset       (rst_n),
      .start       (start),
      .ofifo_valid (ofifo_valid),
      .inst        (inst),
      .busy        (busy),
      .done        (done),
      .kij_idx     (kij_idx),
      .onij_idx    (onij_idx)
   );

   localparam logic [46:0] IDLE_WORD = 47'h6001_800C_0000;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_ap(input int o, input int j);
      return j * 36 + (o / 4 + j / 3) * 6 + (o % 4 + j % 3);
   endfunction

   typedef struct {
      int o;
      int j;
      int exp_ap;
   } acc_vec_t;

   acc_vec_t acc_vec [8];

   // Per-run observations
   int          wcnt  [9];
   int          ldcnt [9];
   int          xcnt  [9];
   int          excnt [9];
   int          ocnt  [9];
   int          jcnt  [16];
   logic [10:0] ap_log [16][9];
   int          acc_rd, acc_pulse, addr_err, misc_err, rd_err, busy_err, done_cnt;

   task automatic run_tile(input bit toggle, input bit poke, input string tag);
      bit       poked = 1'b0;
      bit       finished = 1'b0;
      bit       seen_busy = 1'b0;
      bit       prev_acc_rd = 1'b0;
      bit       valid_applied = 1'b1;
      bit       wr, accrd;
      bit [3:0] pat = 4'b1001;
      int       post = 0;
      int       k, o;

      for (int i = 0; i < 9; i++) begin
         wcnt[i] = 0; ldcnt[i] = 0; xcnt[i] = 0; excnt[i] = 0; ocnt[i] = 0;
      end
      for (int i = 0; i < 16; i++) begin
         jcnt[i] = 0;
         for (int j = 0; j < 9; j++) ap_log[i][j] = '0;
      end
      acc_rd = 0; acc_pulse = 0; addr_err = 0; misc_err = 0;
      rd_err = 0; busy_err = 0; done_cnt = 0;

      ofifo_valid = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      for (int cyc = 0; cyc < 20000 && post < 12; cyc++) begin
         @(negedge clk);
         k = int'(kij_idx);
         if (k > 8) begin misc_err++; k = 0; end

         if (inst[5] || inst[4]) misc_err++;
         if (!busy && inst !== IDLE_WORD) misc_err++;

         if (!inst[19]) begin
            if (int'(inst[17:7]) != k * 8 + wcnt[k]) addr_err++;
            wcnt[k]++;
         end
         if (inst[0]) ldcnt[k]++;
         if (!inst[46]) begin
            if (int'(inst[44:34]) != xcnt[k]) addr_err++;
            xcnt[k]++;
         end
         if (inst[1]) excnt[k]++;

         if (inst[6] && !valid_applied) rd_err++;
         wr = !inst[32] && !inst[31];
         if (wr != inst[6]) misc_err++;
         if (wr) begin
            if (int'(inst[30:20]) != k * 36 + ocnt[k]) addr_err++;
            ocnt[k]++;
         end

         accrd = !inst[32] && inst[31];
         if (inst[33] != prev_acc_rd) misc_err++;
         prev_acc_rd = accrd;
         if (accrd) begin
            o = int'(onij_idx);
            if (o < 16 && jcnt[o] < 9) begin
               ap_log[o][jcnt[o]] = inst[30:20];
               if (int'(inst[30:20]) != model_ap(o, jcnt[o])) addr_err++;
               jcnt[o]++;
            end else begin
               misc_err++;
            end
            acc_rd++;
         end
         if (inst[33]) acc_pulse++;

         if (finished) post++;
         if (done) begin done_cnt++; finished = 1'b1; end
         if (finished && post > 0 && busy) busy_err++;
         if (seen_busy && !busy && !finished) busy_err++;
         if (busy) seen_busy = 1'b1;

         start = 1'b0;
         if (poke && inst[0] && !poked) begin start = 1'b1; poked = 1'b1; end
         if (poke && done) start = 1'b1;

         valid_applied = toggle ? pat[cyc % 4] : 1'b1;
         ofifo_valid   = valid_applied;
      end
      start = 1'b0;
      ofifo_valid = 1'b1;

      check({tag, " done_count"}, done_cnt, 1);
      check({tag, " busy_profile_err"}, busy_err, 0);
      check({tag, " addr_err"}, addr_err, 0);
      check({tag, " misc_err"}, misc_err, 0);
      check({tag, " ofifo_rd_without_valid"}, rd_err, 0);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("%s kij%0d w_rd", tag, i), wcnt[i], 8);
         check($sformatf("%s kij%0d load", tag, i), ldcnt[i], 15);
         check($sformatf("%s kij%0d x_rd", tag, i), xcnt[i], 36);
         check($sformatf("%s kij%0d exec", tag, i), excnt[i], 51);
         check($sformatf("%s kij%0d ofifo_rd", tag, i), ocnt[i], 36);
      end
      check({tag, " acc_reads"}, acc_rd, 144);
      check({tag, " acc_pulses"}, acc_pulse, 144);
   endtask

   initial begin
      int found;

      acc_vec[0] = '{o: 5,  j: 4, exp_ap: 158};
      acc_vec[1] = '{o: 15, j: 8, exp_ap: 323};
      acc_vec[2] = '{o: 0,  j: 0, exp_ap: 0};
      acc_vec[3] = '{o: 0,  j: 8, exp_ap: 302};
      acc_vec[4] = '{o: 3,  j: 0, exp_ap: 3};
      acc_vec[5] = '{o: 4,  j: 1, exp_ap: 43};
      acc_vec[6] = '{o: 10, j: 5, exp_ap: 202};
      acc_vec[7] = '{o: 12, j: 6, exp_ap: 246};

      rst_n = 1'b0;
      start = 1'b0;
      ofifo_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("reset inst_idle", int'(inst === IDLE_WORD), 1);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset kij_idx", int'(kij_idx), 0);
      check("reset onij_idx", int'(onij_idx), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Full tile, OFIFO always valid
      run_tile(1'b0, 1'b0, "t1");

      // Accumulation addresses captured during the t1 run
      for (int i = 0; i < 8; i++) begin
         check($sformatf("acc_addr o%0d j%0d", acc_vec[i].o, acc_vec[i].j),
               int'(ap_log[acc_vec[i].o][acc_vec[i].j]), acc_vec[i].exp_ap);
      end

      // OFIFO valid toggling 1,0,0,1
      run_tile(1'b1, 1'b0, "t3");

      // Reset dropped mid-EXEC at kij=3
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 5000 && found == 0; c++) begin
         @(negedge clk);
         if (kij_idx == 4'd3 && inst[1]) found = 1;
      end
      check("t4 reached exec kij3", found, 1);
      rst_n = 1'b0;
      #1;
      check("t4 async inst_idle", int'(inst === IDLE_WORD), 1);
      check("t4 async busy", int'(busy), 0);
      check("t4 async kij_idx", int'(kij_idx), 0);
      check("t4 async done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_tile(1'b0, 1'b0, "t4_rerun");

      // start pulses in W_LOAD and in the done cycle
      run_tile(1'b0, 1'b1, "t5");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
